// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock set-mode controller.
// Month codes are binary month numbers (1..12) decoded from the BCD inputs.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_YEAR,
    SET_MONTH,
    SET_DAY,
    SET_HOUR,
    SET_MIN
  } set_state_t;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [4:0] MAX_DAYS_DEFAULT = 5'd31;

  // Two-digit BCD value divisible by 4, decided from the digits directly.
  function automatic logic bcd_div4(input logic [3:0] tens, input logic [3:0] units);
    if (!tens[0]) return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    else          return (units == 4'd2) || (units == 4'd6);
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Combinational days-in-month lookup from BCD month/year with Gregorian leap rule.
module days_in_month
  import clock_ctrl_pkg::*;
(
  input  logic [3:0] month_ten_i,
  input  logic [3:0] month_unit_i,
  input  logic [3:0] year_thou_i,
  input  logic [3:0] year_hund_i,
  input  logic [3:0] year_ten_i,
  input  logic [3:0] year_unit_i,
  output logic [4:0] days_o
);

  logic       month_valid;
  logic [3:0] month_bin;
  logic       century;
  logic       leap;

  always_comb begin
    month_valid = ((month_ten_i == 4'd0) && (month_unit_i >= 4'd1) && (month_unit_i <= 4'd9)) ||
                  ((month_ten_i == 4'd1) && (month_unit_i <= 4'd2));
    month_bin   = month_ten_i[0] ? (month_unit_i + 4'd10) : month_unit_i;
    // Century years fall back to the thousands:hundreds pair (mod 400).
    century     = (year_ten_i == 4'd0) && (year_unit_i == 4'd0);
    leap        = century ? bcd_div4(year_thou_i, year_hund_i)
                          : bcd_div4(year_ten_i, year_unit_i);
    days_o      = MAX_DAYS_DEFAULT;
    if (month_valid) begin
      case (month_bin)
        FEB:                days_o = leap ? 5'd29 : 5'd28;
        APR, JUN, SEP, NOV: days_o = 5'd30;
        default:            days_o = MAX_DAYS_DEFAULT;
      endcase
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller: button edges drive the edit FSM, step pulses with
// press-and-hold auto-repeat, inactivity timeout and the max_days register.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 50_000_000,
  parameter int unsigned REPEAT_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] month_ten,
  input  logic [3:0] month_unit,
  input  logic [3:0] year_thou,
  input  logic [3:0] year_hund,
  input  logic [3:0] year_ten,
  input  logic [3:0] year_unit,
  output logic       mode_year,
  output logic       mode_month,
  output logic       mode_day,
  output logic       mode_hour,
  output logic       mode_min,
  output logic       up,
  output logic       down,
  output logic [4:0] max_days,
  output logic       editing
);

  set_state_t  state_q, state_d;
  logic        ready_q;
  logic        mode_prev_q, up_prev_q, dn_prev_q;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic        up_arm_q, up_arm_d, dn_arm_q, dn_arm_d;
  logic        up_rep_q, up_rep_d, dn_rep_q, dn_rep_d;
  logic        up_q, up_d, down_q, down_d;
  logic [4:0]  mode_q, mode_d;
  logic        editing_q, editing_d;
  logic [4:0]  max_days_q, days_w;

  logic mode_rise, up_rise, dn_rise, any_rise, step_ok;

  days_in_month u_dim (
    .month_ten_i  (month_ten),
    .month_unit_i (month_unit),
    .year_thou_i  (year_thou),
    .year_hund_i  (year_hund),
    .year_ten_i   (year_ten),
    .year_unit_i  (year_unit),
    .days_o       (days_w)
  );

  // ready_q masks the first cycle after reset so buttons held through reset
  // are treated as already pressed rather than as fresh rises.
  always_comb begin
    mode_rise = ready_q & btn_mode & ~mode_prev_q;
    up_rise   = ready_q & btn_up   & ~up_prev_q;
    dn_rise   = ready_q & btn_down & ~dn_prev_q;
    any_rise  = mode_rise | up_rise | dn_rise;
    step_ok   = (state_q != RUN) && !mode_rise && !(btn_up && btn_down);

    state_d = state_q;
    if (mode_rise) begin
      case (state_q)
        RUN:       state_d = SET_YEAR;
        SET_YEAR:  state_d = SET_MONTH;
        SET_MONTH: state_d = SET_DAY;
        SET_DAY:   state_d = SET_HOUR;
        SET_HOUR:  state_d = SET_MIN;
        default:   state_d = RUN;
      endcase
    end else if ((state_q != RUN) && !any_rise && (tmr_q >= TIMEOUT_CYC - 1)) begin
      state_d = RUN;
    end
    tmr_d = ((state_d == RUN) || any_rise) ? '0 : tmr_q + 32'd1;

    up_d     = 1'b0;
    up_arm_d = up_arm_q;
    up_rep_d = up_rep_q;
    up_cnt_d = up_cnt_q;
    if (!step_ok || !btn_up) begin
      up_arm_d = 1'b0;
      up_rep_d = 1'b0;
      up_cnt_d = '0;
    end else if (up_rise) begin
      up_d     = 1'b1;
      up_arm_d = 1'b1;
      up_rep_d = 1'b0;
      up_cnt_d = 32'd1;
    end else if (up_arm_q) begin
      if (up_cnt_q == (up_rep_q ? REPEAT_CYC : HOLD_CYC)) begin
        up_d     = 1'b1;
        up_rep_d = 1'b1;
        up_cnt_d = 32'd1;
      end else begin
        up_cnt_d = up_cnt_q + 32'd1;
      end
    end

    down_d   = 1'b0;
    dn_arm_d = dn_arm_q;
    dn_rep_d = dn_rep_q;
    dn_cnt_d = dn_cnt_q;
    if (!step_ok || !btn_down) begin
      dn_arm_d = 1'b0;
      dn_rep_d = 1'b0;
      dn_cnt_d = '0;
    end else if (dn_rise) begin
      down_d   = 1'b1;
      dn_arm_d = 1'b1;
      dn_rep_d = 1'b0;
      dn_cnt_d = 32'd1;
    end else if (dn_arm_q) begin
      if (dn_cnt_q == (dn_rep_q ? REPEAT_CYC : HOLD_CYC)) begin
        down_d   = 1'b1;
        dn_rep_d = 1'b1;
        dn_cnt_d = 32'd1;
      end else begin
        dn_cnt_d = dn_cnt_q + 32'd1;
      end
    end

    mode_d = '1;
    case (state_d)
      SET_YEAR:  mode_d[4] = 1'b0;
      SET_MONTH: mode_d[3] = 1'b0;
      SET_DAY:   mode_d[2] = 1'b0;
      SET_HOUR:  mode_d[1] = 1'b0;
      SET_MIN:   mode_d[0] = 1'b0;
      default:   mode_d    = '1;
    endcase
    editing_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      ready_q     <= 1'b0;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      tmr_q       <= '0;
      up_cnt_q    <= '0;
      dn_cnt_q    <= '0;
      up_arm_q    <= 1'b0;
      dn_arm_q    <= 1'b0;
      up_rep_q    <= 1'b0;
      dn_rep_q    <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      mode_q      <= '1;
      editing_q   <= 1'b0;
      max_days_q  <= MAX_DAYS_DEFAULT;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      mode_prev_q <= btn_mode;
      up_prev_q   <= btn_up;
      dn_prev_q   <= btn_down;
      tmr_q       <= tmr_d;
      up_cnt_q    <= up_cnt_d;
      dn_cnt_q    <= dn_cnt_d;
      up_arm_q    <= up_arm_d;
      dn_arm_q    <= dn_arm_d;
      up_rep_q    <= up_rep_d;
      dn_rep_q    <= dn_rep_d;
      up_q        <= up_d;
      down_q      <= down_d;
      mode_q      <= mode_d;
      editing_q   <= editing_d;
      max_days_q  <= days_w;
    end
  end

  assign mode_year  = mode_q[4];
  assign mode_month = mode_q[3];
  assign mode_day   = mode_q[2];
  assign mode_hour  = mode_q[1];
  assign mode_min   = mode_q[0];
  assign up         = up_q;
  assign down       = down_q;
  assign max_days   = max_days_q;
  assign editing    = editing_q;

endmodule
